// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux2_rr_arbiter
// Brief   : Round-robin owner of a shared 2:1 data path, with bounded tenure
//           and a registered output stage. Optional macro ARB_LOCK_EN adds
//           lock1/lock2 inputs that let the current owner extend its tenure.
// Revision: 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             req2,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef ARB_LOCK_EN
    input  logic             lock1,
    input  logic             lock2,
`endif
    output logic             gnt1,
    output logic             gnt2,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G1   = 2'd1,
        S_G2   = 2'd2
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       w_hold_next;
    logic             r_last2;      // 1 when requester 2 owned the path most recently
    logic             r_sel;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             w_lock1;
    logic             w_lock2;

`ifdef ARB_LOCK_EN
    assign w_lock1 = lock1;
    assign w_lock2 = lock2;
`else
    assign w_lock1 = 1'b0;
    assign w_lock2 = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_hold_next = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (req1 && req2) begin
                    w_next = r_last2 ? S_G1 : S_G2;
                end else if (req1) begin
                    w_next = S_G1;
                end else if (req2) begin
                    w_next = S_G2;
                end
            end
            S_G1: begin
                if (!req1) begin
                    w_next = req2 ? S_G2 : S_IDLE;
                end else if (req2 && !w_lock1) begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_next = S_G2;
                    end else begin
                        w_hold_next = r_hold_cnt + 8'd1;
                    end
                end
            end
            S_G2: begin
                if (!req2) begin
                    w_next = req1 ? S_G1 : S_IDLE;
                end else if (req1 && !w_lock2) begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_next = S_G1;
                    end else begin
                        w_hold_next = r_hold_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Any change of owner starts a fresh tenure.
        if (w_next != r_state) begin
            w_hold_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= 8'd0;
            r_last2     <= 1'b1;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= w_hold_next;
            if ((w_next != r_state) && (r_state != S_IDLE)) begin
                r_last2 <= (r_state == S_G2);
            end
            if (w_next == S_G1) begin
                r_sel <= 1'b0;
            end else if (w_next == S_G2) begin
                r_sel <= 1'b1;
            end
            // Data stage trails the grant by one cycle; in IDLE the last word is kept.
            r_out_valid <= (r_state != S_IDLE);
            if (r_state != S_IDLE) begin
                r_out <= (r_state == S_G1) ? in1 : in2;
            end
        end
    end

    assign gnt1      = (r_state == S_G1);
    assign gnt2      = (r_state == S_G2);
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
